// File: rtl/api_ext_pkg.sv
// Shared encodings for the extension-module API bridge.
// Holds command/status codes, FSM state constants, internal page offsets,
// identification words, error data words and the latched request payload.
package api_ext_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [1:0] COMMAND_IDLE    = 2'd0;
  localparam logic [1:0] COMMAND_READ    = 2'd1;
  localparam logic [1:0] COMMAND_ILLEGAL = 2'd2;
  localparam logic [1:0] COMMAND_WRITE   = 2'd3;

  localparam logic [1:0] STATUS_BUSY  = 2'd0;
  localparam logic [1:0] STATUS_READY = 2'd1;
  localparam logic [1:0] STATUS_ERROR = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] INTERNAL_PREFIX = 8'h00;

  localparam logic [7:0] OFS_NAME0         = 8'h00;
  localparam logic [7:0] OFS_NAME1         = 8'h01;
  localparam logic [7:0] OFS_VERSION       = 8'h02;
  localparam logic [7:0] OFS_NUM_SLAVES    = 8'h03;
  localparam logic [7:0] OFS_OP_A          = 8'h10;
  localparam logic [7:0] OFS_OP_B          = 8'h11;
  localparam logic [7:0] OFS_SUM           = 8'h12;
  localparam logic [7:0] OFS_TIMEOUT_COUNT = 8'h20;
  localparam logic [7:0] OFS_LAST_ERR_ADDR = 8'h21;

  localparam logic [DATA_W-1:0] NAME0_WORD   = 32'h6170692d; // "api-"
  localparam logic [DATA_W-1:0] NAME1_WORD   = 32'h6d757820; // "mux "
  localparam logic [DATA_W-1:0] VERSION_WORD = 32'h302e3330; // "0.30"

  localparam logic [DATA_W-1:0] ERR_ADDR_WORD    = 32'hdeaddead;
  localparam logic [DATA_W-1:0] ERR_TIMEOUT_WORD = 32'hdeadbeef;

  // Request captured when an access is accepted
  typedef struct packed {
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } api_req_t;

endpackage

// File: rtl/api_extension_mux_if.sv
// Host-side I/O port of the extension bridge.
// master: drives command/address/write_data, observes status/read_data.
// slave : the bridge side.
interface api_extension_mux_if;
  logic [1:0]  command;
  logic [1:0]  status;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output command, output address, output write_data,
                  input  status,  input  read_data);
  modport slave  (input  command, input  address, input  write_data,
                  output status,  output read_data);
endinterface

// File: rtl/api_ext_decoder.sv
// Combinational prefix decoder: matches an address prefix byte against the
// per-slave prefix table. Outputs a one-hot select, a hit flag and the index.
// Lowest matching index wins.
module api_ext_decoder #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*8-1:0] SLAVE_PREFIXES = {8'hfe, 8'h40, 8'h20, 8'h10},
  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [7:0]            prefix,
  output logic [NUM_SLAVES-1:0] sel_onehot,
  output logic                  hit,
  output logic [IDX_W-1:0]      sel_idx
);

  // Scan from the top so the lowest matching index is written last
  always_comb begin
    sel_onehot = '0;
    hit        = 1'b0;
    sel_idx    = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if (prefix == SLAVE_PREFIXES[8*i +: 8]) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        hit           = 1'b1;
        sel_idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/api_extension_mux.sv
// API bridge between the host I/O port and NUM_SLAVES extension modules.
// Ports: clk, reset_n (async active-low); host (command/status/address/
// write_data/read_data); slv_cs/slv_we one-hot selects; slv_address and
// slv_write_data shared latched request; slv_read_data/slv_ready per slave.
// Prefix 8'h00 addresses an internal register page.
module api_extension_mux
  import api_ext_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*8-1:0] SLAVE_PREFIXES = {8'hfe, 8'h40, 8'h20, 8'h10},
  parameter int unsigned SLAVE_AW = 24,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  api_extension_mux_if.slave       host,
  output logic [NUM_SLAVES-1:0]    slv_cs,
  output logic [NUM_SLAVES-1:0]    slv_we,
  output logic [SLAVE_AW-1:0]      slv_address,
  output logic [DATA_W-1:0]        slv_write_data,
  input  logic [NUM_SLAVES*32-1:0] slv_read_data,
  input  logic [NUM_SLAVES-1:0]    slv_ready
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic [1:0]        command_reg;
  logic [1:0]        state, state_d;
  api_req_t          req, req_d;
  logic              cs_reg, cs_d, we_reg, we_d;
  logic [2:0]        wait_cnt, wait_d;
  logic [15:0]       tmo_cnt, tmo_d;
  logic [1:0]        status_q, status_d;
  logic [DATA_W-1:0] read_data_q, rdata_d;
  logic              err_evt, tmo_evt;

  logic [NUM_SLAVES-1:0] sel_d, mask_d;
  logic                  hit_d, int_d, err_d;
  logic [IDX_W-1:0]      idx_d, idx_q;
  logic                  int_q, err_q, ready_reg;

  logic [DATA_W-1:0] op_a, op_b, sum_q, last_err_addr;
  logic [15:0]       timeout_count;
  logic [DATA_W-1:0] page_rdata, slave_rdata;
  logic              page_we;

  // Decode the request that will be current next cycle, so selection,
  // ready and chip selects are registered in step with the latched address
  api_ext_decoder #(
    .NUM_SLAVES     (NUM_SLAVES),
    .SLAVE_PREFIXES (SLAVE_PREFIXES)
  ) u_decoder (
    .prefix     (req_d.addr[31:24]),
    .sel_onehot (sel_d),
    .hit        (hit_d),
    .sel_idx    (idx_d)
  );

  assign int_d  = (req_d.addr[31:24] == INTERNAL_PREFIX);
  assign err_d  = (req_d.cmd == COMMAND_ILLEGAL) || (!int_d && !hit_d);
  assign mask_d = (int_d || err_d) ? '0 : sel_d;

  assign slave_rdata = slv_read_data[32*int'(idx_q) +: 32];

  // Internal page read mux
  always_comb begin
    page_rdata = '0;
    case (req.addr[7:0])
      OFS_NAME0:         page_rdata = NAME0_WORD;
      OFS_NAME1:         page_rdata = NAME1_WORD;
      OFS_VERSION:       page_rdata = VERSION_WORD;
      OFS_NUM_SLAVES:    page_rdata = 32'(NUM_SLAVES);
      OFS_OP_A:          page_rdata = op_a;
      OFS_OP_B:          page_rdata = op_b;
      OFS_SUM:           page_rdata = sum_q;
      OFS_TIMEOUT_COUNT: page_rdata = {16'h0000, timeout_count};
      OFS_LAST_ERR_ADDR: page_rdata = last_err_addr;
      default:           page_rdata = '0;
    endcase
  end

  // Access FSM next-state and outputs
  always_comb begin
    state_d  = state;
    req_d    = req;
    cs_d     = cs_reg;
    we_d     = we_reg;
    wait_d   = wait_cnt;
    tmo_d    = tmo_cnt;
    status_d = status_q;
    rdata_d  = read_data_q;
    err_evt  = 1'b0;
    tmo_evt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (command_reg != COMMAND_IDLE) begin
          state_d  = ST_WAIT;
          req_d    = '{cmd: command_reg, addr: host.address, wdata: host.write_data};
          cs_d     = 1'b1;
          we_d     = (command_reg == COMMAND_WRITE);
          status_d = STATUS_BUSY;
          wait_d   = '0;
          tmo_d    = '0;
        end
      end
      ST_WAIT: begin
        if (wait_cnt != 3'(WAIT_CYCLES)) begin
          wait_d = wait_cnt + 3'd1;
        end else if (ready_reg) begin
          state_d = ST_DONE;
          cs_d    = 1'b0;
          we_d    = 1'b0;
          if (err_q) begin
            status_d = STATUS_ERROR;
            rdata_d  = ERR_ADDR_WORD;
            err_evt  = 1'b1;
          end else begin
            status_d = STATUS_READY;
            rdata_d  = int_q ? page_rdata : slave_rdata;
          end
        end else if (tmo_cnt == 16'(TIMEOUT_CYCLES)) begin
          state_d  = ST_DONE;
          cs_d     = 1'b0;
          we_d     = 1'b0;
          status_d = STATUS_ERROR;
          rdata_d  = ERR_TIMEOUT_WORD;
          err_evt  = 1'b1;
          tmo_evt  = 1'b1;
        end else begin
          tmo_d = tmo_cnt + 16'd1;
        end
      end
      ST_DONE: begin
        if (command_reg == COMMAND_IDLE) begin
          state_d  = ST_IDLE;
          status_d = STATUS_READY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and request registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      command_reg    <= COMMAND_IDLE;
      state          <= ST_IDLE;
      req            <= '0;
      cs_reg         <= 1'b0;
      we_reg         <= 1'b0;
      wait_cnt       <= '0;
      tmo_cnt        <= '0;
      status_q       <= STATUS_READY;
      read_data_q    <= '0;
      idx_q          <= '0;
      int_q          <= 1'b0;
      err_q          <= 1'b0;
      ready_reg      <= 1'b0;
      slv_cs         <= '0;
      slv_we         <= '0;
    end else begin
      command_reg    <= host.command;
      state          <= state_d;
      req            <= req_d;
      cs_reg         <= cs_d;
      we_reg         <= we_d;
      wait_cnt       <= wait_d;
      tmo_cnt        <= tmo_d;
      status_q       <= status_d;
      read_data_q    <= rdata_d;
      idx_q          <= idx_d;
      int_q          <= int_d;
      err_q          <= err_d;
      // Internal page and erroneous accesses complete without a slave
      ready_reg      <= (int_d || err_d) ? 1'b1 : slv_ready[idx_d];
      slv_cs         <= {NUM_SLAVES{cs_d}} & mask_d;
      slv_we         <= {NUM_SLAVES{we_d}} & mask_d;
    end
  end

  assign slv_address    = req.addr[SLAVE_AW-1:0];
  assign slv_write_data = req.wdata;
  assign host.status    = status_q;
  assign host.read_data = read_data_q;

  assign page_we = cs_reg && we_reg && int_q;

  // Internal register page
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a          <= '0;
      op_b          <= '0;
      sum_q         <= '0;
      timeout_count <= '0;
      last_err_addr <= '0;
    end else begin
      sum_q <= op_a + op_b;
      if (page_we && req.addr[7:0] == OFS_OP_A) op_a <= req.wdata;
      if (page_we && req.addr[7:0] == OFS_OP_B) op_b <= req.wdata;
      if (page_we && req.addr[7:0] == OFS_TIMEOUT_COUNT) begin
        timeout_count <= '0;
      end else if (tmo_evt && timeout_count != 16'hffff) begin
        timeout_count <= timeout_count + 16'd1;
      end
      if (err_evt) last_err_addr <= req.addr;
    end
  end

endmodule

// File: tb/tb_api_extension_mux.sv
// Scoreboard bench for api_extension_mux: stimulus pushes expected
// completions, a negedge monitor pops and compares on each BUSY->done edge.
module tb_api_extension_mux;
  import api_ext_pkg::*;

  localparam int unsigned NS  = 4;
  localparam int unsigned AW  = 24;
  localparam int unsigned TMO = 8;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] data;
    bit          chk_data;
    int          lat;
    int          issue;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  api_extension_mux_if host();
  logic [NS-1:0]    slv_cs, slv_we, slv_ready;
  logic [AW-1:0]    slv_address;
  logic [31:0]      slv_write_data;
  logic [NS*32-1:0] slv_read_data;

  api_extension_mux #(
    .NUM_SLAVES     (NS),
    .SLAVE_PREFIXES ({8'hfe, 8'h40, 8'h20, 8'h10}),
    .SLAVE_AW       (AW),
    .WAIT_CYCLES    (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .host           (host.slave),
    .slv_cs         (slv_cs),
    .slv_we         (slv_we),
    .slv_address    (slv_address),
    .slv_write_data (slv_write_data),
    .slv_read_data  (slv_read_data),
    .slv_ready      (slv_ready)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t sb[$];
  logic [NS-1:0] cs_acc = '0;
  logic [AW-1:0] addr_cap = '0;
  int we3_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Completion monitor
  initial begin
    logic [1:0] prev;
    exp_t e;
    prev = STATUS_READY;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = STATUS_READY;
      end else begin
        if (prev == STATUS_BUSY && host.status != STATUS_BUSY) begin
          if (sb.size() == 0) begin
            bound_fail("unexpected_completion");
          end else begin
            e = sb.pop_front();
            chk("status", 32'(host.status), 32'(e.st));
            if (e.chk_data) chk("read_data", host.read_data, e.data);
            chk("latency", 32'(cyc - e.issue), 32'(e.lat));
          end
        end
        prev = host.status;
      end
    end
  end

  // Slave-side observer
  initial forever begin
    @(negedge clk);
    cs_acc = cs_acc | slv_cs;
    if (slv_cs != '0) addr_cap = slv_address;
    if (slv_we[3]) we3_cnt++;
  end

  task automatic issue(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] st, input logic [31:0] data, input bit cd, input int lat);
    exp_t e;
    @(negedge clk);
    cs_acc  = '0;
    we3_cnt = 0;
    host.command    = cmd;
    host.address    = addr;
    host.write_data = wd;
    e.st = st; e.data = data; e.chk_data = cd; e.lat = lat; e.issue = cyc;
    sb.push_back(e);
  endtask

  task automatic finish_access();
    int n;
    n = 0;
    while (host.status != STATUS_BUSY && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) bound_fail("wait_busy");
    n = 0;
    while (host.status == STATUS_BUSY && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) bound_fail("wait_done");
    host.command = COMMAND_IDLE;
    repeat (3) @(negedge clk);
  endtask

  task automatic access(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] st, input logic [31:0] data, input bit cd, input int lat);
    issue(cmd, addr, wd, st, data, cd, lat);
    finish_access();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    host.command    = COMMAND_IDLE;
    host.address    = '0;
    host.write_data = '0;
    slv_ready       = 4'b0101;
    slv_read_data   = {32'h33333333, 32'h12345678, 32'h22222222, 32'h00001111};
    repeat (3) @(negedge clk);
    chk("rst_status", 32'(host.status), 32'(STATUS_READY));
    chk("rst_read_data", host.read_data, 32'h0);
    chk("rst_cs", 32'(slv_cs), 32'h0);
    chk("rst_we", 32'(slv_we), 32'h0);
    chk("rst_slv_address", 32'(slv_address), 32'h0);
    chk("rst_slv_wdata", slv_write_data, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Internal adder
    access(COMMAND_WRITE, 32'h00000010, 32'd5, STATUS_READY, 32'h0, 1'b0, 5);
    access(COMMAND_WRITE, 32'h00000011, 32'd7, STATUS_READY, 32'h0, 1'b0, 5);
    access(COMMAND_READ,  32'h00000012, 32'h0, STATUS_READY, 32'd12, 1'b1, 5);
    access(COMMAND_READ,  32'h00000000, 32'h0, STATUS_READY, 32'h6170692d, 1'b1, 5);
    access(COMMAND_READ,  32'h00000002, 32'h0, STATUS_READY, 32'h302e3330, 1'b1, 5);
    access(COMMAND_READ,  32'h00000003, 32'h0, STATUS_READY, 32'd4, 1'b1, 5);
    access(COMMAND_READ,  32'h00000050, 32'h0, STATUS_READY, 32'h0, 1'b1, 5);
    access(COMMAND_WRITE, 32'h00000001, 32'hffffffff, STATUS_READY, 32'h0, 1'b0, 5);
    access(COMMAND_READ,  32'h00000001, 32'h0, STATUS_READY, 32'h6d757820, 1'b1, 5);

    // Slave 2 read
    access(COMMAND_READ, 32'h40000abc, 32'h0, STATUS_READY, 32'h12345678, 1'b1, 5);
    chk("slave2_cs", 32'(cs_acc), 32'h4);
    chk("slave2_addr", 32'(addr_cap), 32'h000abc);

    // Slave 1 timeout
    access(COMMAND_READ, 32'h20000000, 32'h0, STATUS_ERROR, 32'hdeadbeef, 1'b1, 13);
    chk("slave1_cs", 32'(cs_acc), 32'h2);
    access(COMMAND_READ, 32'h00000020, 32'h0, STATUS_READY, 32'd1, 1'b1, 5);
    access(COMMAND_READ, 32'h00000021, 32'h0, STATUS_READY, 32'h20000000, 1'b1, 5);

    // Address error
    access(COMMAND_READ, 32'h77000000, 32'h0, STATUS_ERROR, 32'hdeaddead, 1'b1, 5);
    chk("addr_err_cs", 32'(cs_acc), 32'h0);
    access(COMMAND_READ, 32'h00000021, 32'h0, STATUS_READY, 32'h77000000, 1'b1, 5);

    // Illegal command aimed at slave 0
    access(COMMAND_ILLEGAL, 32'h10000004, 32'h0, STATUS_ERROR, 32'hdeaddead, 1'b1, 5);
    chk("illegal_cs", 32'(cs_acc), 32'h0);
    access(COMMAND_READ, 32'h00000021, 32'h0, STATUS_READY, 32'h10000004, 1'b1, 5);

    // Slave 3 write, ready four cycles after the wait count expires
    slv_ready[3] = 1'b0;
    issue(COMMAND_WRITE, 32'hfe000010, 32'ha5a5a5a5, STATUS_READY, 32'h33333333, 1'b1, 10);
    repeat (8) @(posedge clk);
    @(negedge clk);
    slv_ready[3] = 1'b1;
    finish_access();
    slv_ready[3] = 1'b0;
    chk("slave3_we_cycles", 32'(we3_cnt), 32'd8);
    chk("slave3_cs", 32'(cs_acc), 32'h8);
    chk("slave3_addr", 32'(addr_cap), 32'h000010);
    chk("slave3_wdata", slv_write_data, 32'ha5a5a5a5);

    // TIMEOUT_COUNT write clears it, then re-arm with another timeout
    access(COMMAND_WRITE, 32'h00000020, 32'h12345678, STATUS_READY, 32'h0, 1'b0, 5);
    access(COMMAND_READ,  32'h00000020, 32'h0, STATUS_READY, 32'd0, 1'b1, 5);
    access(COMMAND_READ,  32'h20000004, 32'h0, STATUS_ERROR, 32'hdeadbeef, 1'b1, 13);
    access(COMMAND_READ,  32'h00000020, 32'h0, STATUS_READY, 32'd1, 1'b1, 5);

    // Reset during WAIT
    @(negedge clk);
    host.command = COMMAND_READ;
    host.address = 32'h10000000;
    repeat (3) @(negedge clk);
    chk("mid_cs_before_reset", 32'(slv_cs), 32'h1);
    chk("mid_status_before_reset", 32'(host.status), 32'(STATUS_BUSY));
    reset_n = 1'b0;
    #1;
    chk("mid_reset_cs", 32'(slv_cs), 32'h0);
    chk("mid_reset_status", 32'(host.status), 32'(STATUS_READY));
    chk("mid_reset_read_data", host.read_data, 32'h0);
    host.command = COMMAND_IDLE;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    access(COMMAND_READ, 32'h00000020, 32'h0, STATUS_READY, 32'd0, 1'b1, 5);
    access(COMMAND_READ, 32'h00000010, 32'h0, STATUS_READY, 32'd0, 1'b1, 5);
    access(COMMAND_READ, 32'h00000021, 32'h0, STATUS_READY, 32'd0, 1'b1, 5);

    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
